// File: rtl/prv664_flush_sequencer.sv
// Commit-stage flush front end: arbitrates CSR and commit flush requests and
// sequences fence.i through LSU drain, D-cache writeback and I-cache invalidate.
module prv664_flush_sequencer #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic            instr_flush_req,
    input  logic [XLEN-1:0] instr_flush_pc,
    input  logic            instr_fencei,
    input  logic            csr_flush_req,
    input  logic [XLEN-1:0] csr_flush_pc,
    input  logic            csr_hold_req,
    input  logic            lsu_idle_i,
    output logic            dcache_wb_req_o,
    input  logic            dcache_wb_ack_i,
    output logic            icache_inv_req_o,
    input  logic            icache_inv_ack_i,
    output logic            flush_o,
    output logic [XLEN-1:0] newpc_o,
    output logic            flushbpu_o,
    output logic            hold_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_WB    = 3'd2,
        ST_INV   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] tgt_pc, tgt_pc_nxt;
    logic            bpu_f, bpu_f_nxt;
    logic            csr_pend, csr_pend_nxt;
    logic            seq_busy;

    // State and flush-target registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= ST_IDLE;
            tgt_pc   <= '0;
            bpu_f    <= 1'b0;
            csr_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            tgt_pc   <= tgt_pc_nxt;
            bpu_f    <= bpu_f_nxt;
            csr_pend <= csr_pend_nxt;
        end
    end

    // Next-state, target capture and state-decoded outputs
    always_comb begin
        state_nxt        = state;
        tgt_pc_nxt       = tgt_pc;
        bpu_f_nxt        = bpu_f;
        csr_pend_nxt     = csr_pend;
        seq_busy         = 1'b0;
        dcache_wb_req_o  = 1'b0;
        icache_inv_req_o = 1'b0;
        flush_o          = 1'b0;
        flushbpu_o       = 1'b0;
        busy_o           = 1'b1;

        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (csr_flush_req) begin
                    tgt_pc_nxt = csr_flush_pc;
                    bpu_f_nxt  = 1'b0;
                    state_nxt  = ST_FLUSH;
                end else if (instr_flush_req) begin
                    tgt_pc_nxt = instr_flush_pc;
                    bpu_f_nxt  = instr_fencei;
                    state_nxt  = instr_fencei ? ST_DRAIN : ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                seq_busy = 1'b1;
                if (lsu_idle_i) state_nxt = ST_WB;
            end
            ST_WB: begin
                seq_busy        = 1'b1;
                dcache_wb_req_o = 1'b1;
                if (dcache_wb_ack_i) state_nxt = ST_INV;
            end
            ST_INV: begin
                seq_busy         = 1'b1;
                icache_inv_req_o = 1'b1;
                if (icache_inv_ack_i) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_o      = 1'b1;
                flushbpu_o   = bpu_f;
                bpu_f_nxt    = 1'b0;
                csr_pend_nxt = 1'b0;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A trap raised mid-sequence retargets the flush; the cache sequence still finishes
        if (seq_busy && csr_flush_req) begin
            csr_pend_nxt = 1'b1;
            tgt_pc_nxt   = csr_flush_pc;
        end
    end

    assign newpc_o = tgt_pc;
    assign hold_o  = csr_hold_req | seq_busy;

    csr_pend_idle_a: assert property (@(posedge clk_i) disable iff (srst_i)
        (state == ST_IDLE) |-> !csr_pend);

endmodule

// File: tb/tb_prv664_flush_sequencer.sv
// Scoreboard bench for prv664_flush_sequencer: stimulus queues expected flushes,
// a negedge monitor checks every flush_o pulse against the queue.
module tb_prv664_flush_sequencer;

    localparam int unsigned XLEN = 64;

    logic            clk_i = 1'b0;
    logic            srst_i = 1'b1;
    logic            instr_flush_req = 1'b0;
    logic [XLEN-1:0] instr_flush_pc = '0;
    logic            instr_fencei = 1'b0;
    logic            csr_flush_req = 1'b0;
    logic [XLEN-1:0] csr_flush_pc = '0;
    logic            csr_hold_req = 1'b0;
    logic            lsu_idle_i = 1'b1;
    logic            dcache_wb_req_o;
    logic            dcache_wb_ack_i = 1'b0;
    logic            icache_inv_req_o;
    logic            icache_inv_ack_i = 1'b0;
    logic            flush_o;
    logic [XLEN-1:0] newpc_o;
    logic            flushbpu_o;
    logic            hold_o;
    logic            busy_o;

    prv664_flush_sequencer #(.XLEN(XLEN)) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .instr_flush_req  (instr_flush_req),
        .instr_flush_pc   (instr_flush_pc),
        .instr_fencei     (instr_fencei),
        .csr_flush_req    (csr_flush_req),
        .csr_flush_pc     (csr_flush_pc),
        .csr_hold_req     (csr_hold_req),
        .lsu_idle_i       (lsu_idle_i),
        .dcache_wb_req_o  (dcache_wb_req_o),
        .dcache_wb_ack_i  (dcache_wb_ack_i),
        .icache_inv_req_o (icache_inv_req_o),
        .icache_inv_ack_i (icache_inv_ack_i),
        .flush_o          (flush_o),
        .newpc_o          (newpc_o),
        .flushbpu_o       (flushbpu_o),
        .hold_o           (hold_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              cyc;
        logic [XLEN-1:0] pc;
        logic            bpu;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    // Monitor: every flush pulse must match the head of the scoreboard
    always @(negedge clk_i) begin
        if (flush_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flush: got flush pc %h expected none (cycle %0d)", newpc_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check64("flush_cycle", 64'(cyc), 64'(e.cyc));
                check64("flush_pc", newpc_o, e.pc);
                check1("flush_bpu", flushbpu_o, e.bpu);
            end
        end
        if (dcache_wb_req_o || icache_inv_req_o)
            check1("req_exclusive", dcache_wb_req_o & icache_inv_req_o, 1'b0);
    end

    int n;

    initial begin
        // Reset
        step(); step();
        sample();
        check1("rst_flush", flush_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_wb", dcache_wb_req_o, 1'b0);
        check1("rst_inv", icache_inv_req_o, 1'b0);
        step();
        srst_i = 1'b0;
        csr_hold_req = 1'b1;
        sample();
        check64("rst_newpc", newpc_o, 64'h0);
        check1("rst_bpu", flushbpu_o, 1'b0);
        check1("hold_passthru_1", hold_o, 1'b1);
        step();
        csr_hold_req = 1'b0;
        sample();
        check1("hold_passthru_0", hold_o, 1'b0);

        // Plain redirect
        step();
        n = cyc;
        instr_flush_req = 1'b1;
        instr_flush_pc  = 64'h8000_0100;
        q.push_back('{n + 1, 64'h8000_0100, 1'b0});
        step();
        instr_flush_req = 1'b0;
        sample();
        check1("p1_busy", busy_o, 1'b1);
        check1("p1_hold", hold_o, 1'b0);
        step();
        sample();
        check1("p1_idle", busy_o, 1'b0);

        // Simultaneous CSR and commit: CSR wins
        step();
        n = cyc;
        csr_flush_req   = 1'b1;
        csr_flush_pc    = 64'h8000_0004;
        instr_flush_req = 1'b1;
        instr_flush_pc  = 64'h8000_0200;
        q.push_back('{n + 1, 64'h8000_0004, 1'b0});
        step();
        csr_flush_req   = 1'b0;
        instr_flush_req = 1'b0;
        step();
        step();

        // fence.i with slow LSU and delayed acks, stray acks in wrong states
        step();
        n = cyc;
        instr_flush_req = 1'b1;
        instr_fencei    = 1'b1;
        instr_flush_pc  = 64'h8000_0400;
        lsu_idle_i      = 1'b0;
        q.push_back('{n + 14, 64'h8000_0400, 1'b1});
        for (int k = 1; k <= 14; k++) begin
            step();
            instr_flush_req  = 1'b0;
            instr_fencei     = 1'b0;
            lsu_idle_i       = (k >= 6);
            dcache_wb_ack_i  = (k == 10) || (k == 4);
            icache_inv_ack_i = (k == 13) || (k == 3) || (k == 8);
            sample();
            check1($sformatf("fi_hold_k%0d", k), hold_o, k <= 13);
            check1($sformatf("fi_wb_k%0d", k), dcache_wb_req_o, (k >= 7) && (k <= 10));
            check1($sformatf("fi_inv_k%0d", k), icache_inv_req_o, (k >= 11) && (k <= 13));
        end
        dcache_wb_ack_i  = 1'b0;
        icache_inv_ack_i = 1'b0;
        lsu_idle_i       = 1'b1;
        step();
        sample();
        check1("fi_done_busy", busy_o, 1'b0);

        // Interrupt during WB retargets the flush; commit and late CSR requests ignored
        step();
        n = cyc;
        instr_flush_req = 1'b1;
        instr_fencei    = 1'b1;
        instr_flush_pc  = 64'h8000_0300;
        q.push_back('{n + 5, 64'h8000_0010, 1'b1});
        step();
        instr_flush_req = 1'b0;
        instr_fencei    = 1'b0;
        step();
        csr_flush_req = 1'b1;
        csr_flush_pc  = 64'h8000_0010;
        sample();
        check1("irq_wb_req", dcache_wb_req_o, 1'b1);
        step();
        csr_flush_req   = 1'b0;
        dcache_wb_ack_i = 1'b1;
        instr_flush_req = 1'b1;
        instr_flush_pc  = 64'h8000_0bad;
        step();
        dcache_wb_ack_i  = 1'b0;
        instr_flush_req  = 1'b0;
        icache_inv_ack_i = 1'b1;
        sample();
        check1("irq_inv_req", icache_inv_req_o, 1'b1);
        step();
        icache_inv_ack_i = 1'b0;
        csr_flush_req    = 1'b1;
        csr_flush_pc     = 64'h8000_0999;
        sample();
        check1("irq_flush_hold", hold_o, 1'b0);
        step();
        csr_flush_req = 1'b0;
        sample();
        check1("irq_done_busy", busy_o, 1'b0);

        // Best-case fence.i latency with a CSR retarget overwritten later
        step();
        n = cyc;
        instr_flush_req = 1'b1;
        instr_fencei    = 1'b1;
        instr_flush_pc  = 64'h8000_0500;
        q.push_back('{n + 4, 64'h8000_0080, 1'b1});
        step();
        instr_flush_req = 1'b0;
        instr_fencei    = 1'b0;
        csr_flush_req   = 1'b1;
        csr_flush_pc    = 64'h8000_0040;
        step();
        csr_flush_req   = 1'b0;
        dcache_wb_ack_i = 1'b1;
        step();
        dcache_wb_ack_i  = 1'b0;
        icache_inv_ack_i = 1'b1;
        csr_flush_req    = 1'b1;
        csr_flush_pc     = 64'h8000_0080;
        step();
        icache_inv_ack_i = 1'b0;
        csr_flush_req    = 1'b0;
        step();

        // Reset mid-WB; the late ack must not restart anything
        step();
        instr_flush_req = 1'b1;
        instr_fencei    = 1'b1;
        instr_flush_pc  = 64'h8000_0600;
        step();
        instr_flush_req = 1'b0;
        instr_fencei    = 1'b0;
        step();
        srst_i = 1'b1;
        sample();
        check1("rstwb_req_before", dcache_wb_req_o, 1'b1);
        step();
        srst_i          = 1'b0;
        dcache_wb_ack_i = 1'b1;
        sample();
        check1("rstwb_req_after", dcache_wb_req_o, 1'b0);
        check1("rstwb_busy", busy_o, 1'b0);
        step();
        dcache_wb_ack_i = 1'b0;
        sample();
        check1("rstwb_busy2", busy_o, 1'b0);
        check1("rstwb_inv", icache_inv_req_o, 1'b0);
        check1("rstwb_hold", hold_o, 1'b0);

        // Back-to-back commit flushes; the one in the FLUSH cycle is dropped
        step();
        n = cyc;
        instr_flush_req = 1'b1;
        instr_flush_pc  = 64'h8000_0700;
        q.push_back('{n + 1, 64'h8000_0700, 1'b0});
        step();
        instr_flush_pc = 64'h8000_0dea;
        step();
        instr_flush_pc = 64'h8000_0800;
        q.push_back('{n + 3, 64'h8000_0800, 1'b0});
        step();
        instr_flush_req = 1'b0;
        step(); step(); step();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending flushes expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prv664_flush_sequencer.md
# prv664_flush_sequencer

Sequential front end to the pipeline flush interface. It arbitrates flush requests from instruction commit and from the CSR unit, and registers the winning flush target. For a commit-side fence.i it runs a multi-cycle sequence before the flush: hold, LSU drain, D-cache writeback, I-cache invalidate. Sits in the commit stage and drives the flush/hold/newpc/flushbpu signals seen by every pipeline stage.

## Interface
- XLEN, 64, width of PC values.
- clk_i  in  1  core clock; all state changes on rising edge.
- srst_i  in  1  synchronous reset, active-high.
- instr_flush_req  in  1  commit requests a flush (mispredict, exception return path, fence.i); single-cycle pulse.
- instr_flush_pc  in  XLEN  redirect PC for instr_flush_req.
- instr_fencei  in  1  qualifies instr_flush_req as fence.i; ignored unless instr_flush_req=1.
- csr_flush_req  in  1  CSR flush request (trap, xRET, satp write); single-cycle pulse.
- csr_flush_pc  in  XLEN  redirect PC for csr_flush_req.
- csr_hold_req  in  1  CSR hold request; passed through to hold_o.
- lsu_idle_i  in  1  LSU and store buffer empty.
- dcache_wb_req_o  out  1  D-cache writeback-all request; level.
- dcache_wb_ack_i  in  1  D-cache writeback done; single-cycle pulse.
- icache_inv_req_o  out  1  I-cache invalidate-all request; level.
- icache_inv_ack_i  in  1  I-cache invalidate done; single-cycle pulse.
- flush_o  out  1  pipeline flush; registered, one-cycle pulse.
- newpc_o  out  XLEN  redirect PC; valid when flush_o=1.
- flushbpu_o  out  1  flush the BPU along with the pipeline; valid when flush_o=1.
- hold_o  out  1  stall all stages.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, DRAIN, WB, INV, FLUSH. Registers: state, tgt_pc (XLEN), bpu_f, csr_pend.
- IDLE:
  - csr_flush_req=1 wins over commit: tgt_pc<=csr_flush_pc, bpu_f<=0, go to FLUSH.
  - Otherwise instr_flush_req=1 with instr_fencei=0: tgt_pc<=instr_flush_pc, bpu_f<=0, go to FLUSH.
  - Otherwise instr_flush_req=1 with instr_fencei=1: tgt_pc<=instr_flush_pc, bpu_f<=1, go to DRAIN.
- DRAIN: wait for lsu_idle_i=1, then go to WB.
- WB: dcache_wb_req_o=1 (combinational from state). Go to INV on dcache_wb_ack_i=1.
- INV: icache_inv_req_o=1. Go to FLUSH on icache_inv_ack_i=1.
- FLUSH: flush_o=1, newpc_o=tgt_pc, flushbpu_o=bpu_f. Return to IDLE; clear bpu_f and csr_pend.
- hold_o = csr_hold_req | (state in DRAIN, WB, INV). hold_o is 0 in FLUSH unless csr_hold_req=1.
- csr_flush_req during DRAIN/WB/INV:
  - Sets csr_pend and tgt_pc<=csr_flush_pc. The CSR PC overrides the fence.i target.
  - The cache sequence still completes; flushbpu_o stays 1.
  - A later csr_flush_req in the same sequence overwrites tgt_pc again.
- instr_flush_req while busy_o=1 (including FLUSH) is ignored. Commit is held or flushed in those cycles, so no such request is legal.
- csr_flush_req in FLUSH is ignored: the instruction causing it is being flushed.
- Acks arriving in a state other than their own are ignored.

## Timing
- Reset (srst_i=1 at an edge), effective next cycle:
  - state=IDLE; flush_o=0, newpc_o=0, flushbpu_o=0, busy_o=0, dcache_wb_req_o=0, icache_inv_req_o=0.
  - hold_o follows csr_hold_req only; tgt_pc=0, bpu_f=0, csr_pend=0.
  - Reset mid-sequence drops cache requests immediately; a late ack after reset is ignored.
- Normal flush: request in cycle N, flush_o=1 in N+1 only, IDLE again in N+2. A new request is accepted in N+2.
- fence.i best case (lsu_idle_i=1, acks same cycle as request): request N, DRAIN N+1, WB N+2, INV N+3, FLUSH N+4. Minimum latency 4 cycles.
- Each wait state holds indefinitely for its condition; there is no timeout.
- dcache_wb_req_o and icache_inv_req_o are never high at the same time. Each stays high until the cycle of its ack, inclusive.

## Test plan
- Plain redirect: instr_flush_req=1, instr_flush_pc=0x8000_0100 in N -> flush_o=1, newpc_o=0x8000_0100, flushbpu_o=0 in N+1 only; hold_o=0 throughout.
- Simultaneous requests: csr_flush_req (pc 0x8000_0004) and instr_flush_req (pc 0x8000_0200) in N -> single flush in N+1 with newpc_o=0x8000_0004.
- fence.i with lsu_idle_i low 5 cycles, wb ack 3 cycles after req, inv ack 2 cycles after req:
  - hold_o=1 from N+1 until FLUSH.
  - Requests are mutually exclusive.
  - flush_o=1 with flushbpu_o=1, newpc_o=instr pc.
- Interrupt during fence.i: csr_flush_req pc 0x8000_0010 while in WB -> sequence completes; flush has newpc_o=0x8000_0010 and flushbpu_o=1.
- Reset mid-WB: srst_i pulse -> dcache_wb_req_o=0 next cycle. A subsequent dcache_wb_ack_i is ignored, no flush occurs, and busy_o=0.
- Back-to-back: commit flushes in N and N+2 -> flush_o pulses in N+1 and N+3. A commit flush in N+1 is ignored.
